// File: rtl/arith_rs_param.sv
// arith_rs_param: parametrised arithmetic reservation station.
// Holds up to DEPTH dispatched instructions, captures operands from CDB_N
// result buses (including bypass at dispatch) and issues the oldest ready
// entry into a registered valid/ready stage towards the ALU.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable (state holds when low)
//   misbranch_flag      synchronous flush
//   disp_*              dispatch request and instruction fields
//   full, count         occupancy (combinational from state)
//   cdb_valid/rob/data  CDB result ports, port p at [p*W +: W]
//   iss_*               issue register, valid/ready handshake with the ALU
module arith_rs_param #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int OP_W   = 6,
  parameter int CDB_N  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      misbranch_flag,
  input  logic                      disp_valid,
  input  logic [OP_W-1:0]           disp_op,
  input  logic [DATA_W-1:0]         disp_v1,
  input  logic [DATA_W-1:0]         disp_v2,
  input  logic [ROB_W-1:0]          disp_q1,
  input  logic [ROB_W-1:0]          disp_q2,
  input  logic [DATA_W-1:0]         disp_pc,
  input  logic [DATA_W-1:0]         disp_imm,
  input  logic [ROB_W-1:0]          disp_rob,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  input  logic [CDB_N-1:0]          cdb_valid,
  input  logic [CDB_N*ROB_W-1:0]    cdb_rob,
  input  logic [CDB_N*DATA_W-1:0]   cdb_data,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [OP_W-1:0]           iss_op,
  output logic [DATA_W-1:0]         iss_v1,
  output logic [DATA_W-1:0]         iss_v2,
  output logic [DATA_W-1:0]         iss_pc,
  output logic [DATA_W-1:0]         iss_imm,
  output logic [ROB_W-1:0]          iss_rob
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]  busy;
  logic [OP_W-1:0]   e_op  [DEPTH];
  logic [DATA_W-1:0] e_v1  [DEPTH];
  logic [DATA_W-1:0] e_v2  [DEPTH];
  logic [ROB_W-1:0]  e_q1  [DEPTH];
  logic [ROB_W-1:0]  e_q2  [DEPTH];
  logic [DATA_W-1:0] e_pc  [DEPTH];
  logic [DATA_W-1:0] e_imm [DEPTH];
  logic [ROB_W-1:0]  e_rob [DEPTH];
  // older[i][j] = 1 : entry i was allocated before entry j
  logic [DEPTH-1:0]  older [DEPTH];

  logic [DEPTH-1:0]  ready_vec, sel_vec;
  logic              sel_found;
  logic [IW-1:0]     sel_idx, free_idx;
  logic [CW-1:0]     cnt;
  logic [DATA_W:0]   wk1 [DEPTH];
  logic [DATA_W:0]   wk2 [DEPTH];
  logic [DATA_W:0]   bp1, bp2;
  logic              issue_slot;

  // Returns {hit, data}; iterating downwards lets the lowest matching port win.
  // Tag 0 means "already ready" and never matches.
  function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_W-1:0] q);
    logic [DATA_W:0] r;
    r = '0;
    for (int p = CDB_N - 1; p >= 0; p--) begin
      if (q != '0 && cdb_valid[p] && cdb_rob[p*ROB_W +: ROB_W] == q)
        r = {1'b1, cdb_data[p*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  always_comb begin
    bp1 = cdb_lookup(disp_q1);
    bp2 = cdb_lookup(disp_q2);
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i]       = cdb_lookup(e_q1[i]);
      wk2[i]       = cdb_lookup(e_q2[i]);
      ready_vec[i] = busy[i] && e_q1[i] == '0 && e_q2[i] == '0;
      cnt          = cnt + CW'(busy[i]);
    end
    // Oldest ready: a ready entry survives unless some other ready entry is older.
    sel_vec = ready_vec;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (j != i && ready_vec[j] && older[j][i]) sel_vec[i] = 1'b0;
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (sel_vec[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
      if (!busy[i]) free_idx = IW'(i);
    end
  end

  assign count      = cnt;
  assign full       = &busy;
  assign issue_slot = !iss_valid || iss_ready;

  always_ff @(posedge clk) begin
    if (rst || misbranch_flag) begin
      busy      <= '0;
      iss_valid <= 1'b0;
      iss_op    <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      if (rst) begin
        iss_v1  <= '0;
        iss_v2  <= '0;
        iss_pc  <= '0;
        iss_imm <= '0;
        iss_rob <= '0;
      end
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && wk1[i][DATA_W]) begin
          e_v1[i] <= wk1[i][DATA_W-1:0];
          e_q1[i] <= '0;
        end
        if (busy[i] && wk2[i][DATA_W]) begin
          e_v2[i] <= wk2[i][DATA_W-1:0];
          e_q2[i] <= '0;
        end
      end

      if (issue_slot) begin
        if (sel_found) begin
          iss_valid      <= 1'b1;
          iss_op         <= e_op[sel_idx];
          iss_v1         <= e_v1[sel_idx];
          iss_v2         <= e_v2[sel_idx];
          iss_pc         <= e_pc[sel_idx];
          iss_imm        <= e_imm[sel_idx];
          iss_rob        <= e_rob[sel_idx];
          busy[sel_idx]  <= 1'b0;
        end else begin
          iss_valid <= 1'b0;
          iss_op    <= '0;
        end
      end

      // free_idx comes from pre-edge busy, so it never collides with sel_idx.
      if (disp_valid && !full) begin
        busy[free_idx]  <= 1'b1;
        e_op[free_idx]  <= disp_op;
        e_pc[free_idx]  <= disp_pc;
        e_imm[free_idx] <= disp_imm;
        e_rob[free_idx] <= disp_rob;
        e_v1[free_idx]  <= bp1[DATA_W] ? bp1[DATA_W-1:0] : disp_v1;
        e_q1[free_idx]  <= bp1[DATA_W] ? '0 : disp_q1;
        e_v2[free_idx]  <= bp2[DATA_W] ? bp2[DATA_W-1:0] : disp_v2;
        e_q2[free_idx]  <= bp2[DATA_W] ? '0 : disp_q2;
        for (int j = 0; j < DEPTH; j++) begin
          older[j][free_idx] <= busy[j];
          older[free_idx][j] <= 1'b0;
        end
      end
    end
  end
endmodule
